// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - vectored interrupt controller, fixed priority (lowest index wins)
// Optional INT_CTRL_MASK_EN adds a software mask (8'h5A) and pending readback (8'h5B).
module int_ctrl #(
    parameter int NUM_SRC    = 8,
    parameter int VEC_W      = 6,
    parameter int VEC_BASE   = 1,
    parameter int VEC_STRIDE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_req,
    output logic [NUM_SRC-1:0] irq_exec,
    input  logic               sreg_i,
    output logic               cpu_int_req,
    output logic [VEC_W-1:0]   cpu_int_vec,
    input  logic               cpu_int_ack,
    input  logic               read,
    input  logic               write,
    input  logic [7:0]         addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   win_idx;
    logic               hold_cnt;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] eff;
    logic               any_eff;

`ifdef INT_CTRL_MASK_EN
    localparam logic [7:0] ADDR_MASK = 8'h5A;
    localparam logic [7:0] ADDR_PEND = 8'h5B;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask <= '1;
        end else if (write && (addr == ADDR_MASK)) begin
            mask <= wdata[NUM_SRC-1:0];
        end
    end

    always_comb begin
        rdata = 'x;
        if (read) begin
            case (addr)
                ADDR_MASK: rdata = 8'(mask);
                ADDR_PEND: rdata = 8'(eff);
                default:   rdata = 'x;
            endcase
        end
    end
`else
    logic unused_bus;

    assign mask       = '1;
    assign rdata      = 'x;
    assign unused_bus = &{1'b0, read, write, addr, wdata};
`endif

    assign eff     = irq_req & mask;
    assign any_eff = |eff;

    always_comb begin
        win_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eff[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // idx and the vector are latched on entry to REQ so a later, higher-priority
    // arrival cannot swap the vector the CPU may already be fetching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            hold_cnt    <= 1'b0;
            cpu_int_req <= 1'b0;
            cpu_int_vec <= '0;
            irq_exec    <= '0;
        end else begin
            irq_exec <= '0;
            case (state)
                ST_IDLE: begin
                    if (sreg_i && any_eff) begin
                        idx         <= win_idx;
                        cpu_int_vec <= VEC_W'(VEC_BASE + int'(win_idx) * VEC_STRIDE);
                        cpu_int_req <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (cpu_int_ack) begin
                        cpu_int_req <= 1'b0;
                        irq_exec    <= NUM_SRC'(1) << idx;
                        hold_cnt    <= 1'b0;
                        state       <= ST_HOLD;
                    end else if (!sreg_i || !eff[idx]) begin
                        cpu_int_req <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    // Two dead cycles let the peripheral's registered flag clear.
                    if (hold_cnt) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= 1'b1;
                    end
                end
                default: begin
                    cpu_int_req <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl
`timescale 1ns/1ps
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_req;
    logic [7:0] irq_exec;
    logic       sreg_i;
    logic       cpu_int_req;
    logic [5:0] cpu_int_vec;
    logic       cpu_int_ack;
    logic       read;
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] req;
        logic [5:0] vec;
        logic [7:0] exec;
    } vec_t;

    vec_t tbl[6];

    int_ctrl dut (
        .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .irq_exec(irq_exec),
        .sreg_i(sreg_i), .cpu_int_req(cpu_int_req), .cpu_int_vec(cpu_int_vec),
        .cpu_int_ack(cpu_int_ack), .read(read), .write(write), .addr(addr),
        .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every irq_exec pulse must match the oldest expected pulse, one per ack.
    always @(posedge clk) begin
        logic [7:0] e;
        #1;
        if (irq_exec !== 8'h00) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_exec: got %0h want 0", irq_exec);
            end else begin
                e = exp_q.pop_front();
                chk("irq_exec", 32'(irq_exec), 32'(e));
            end
        end
    end

    task automatic wait_req(input string name, input int limit);
        int n = 0;
        while (cpu_int_req !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk({name, "_req_timeout"}, 32'(cpu_int_req), 32'd1);
    endtask

    task automatic do_ack(input logic [7:0] exp_exec);
        cpu_int_ack = 1'b1;
        exp_q.push_back(exp_exec);
        tick();
        cpu_int_ack = 1'b0;
        chk("req_after_ack", 32'(cpu_int_req), 32'd0);
    endtask

    task automatic go_idle();
        irq_req     = 8'h00;
        cpu_int_ack = 1'b0;
        read        = 1'b0;
        write       = 1'b0;
        tick(4);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        write = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        write = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [7:0] a, input logic [7:0] exp);
        read = 1'b1;
        addr = a;
        #1;
        chk(name, 32'(rdata), 32'(exp));
        read = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int hits;
        tbl[0] = '{8'h01, 6'd1, 8'h01};
        tbl[1] = '{8'h80, 6'd8, 8'h80};
        tbl[2] = '{8'h24, 6'd3, 8'h04};
        tbl[3] = '{8'hF0, 6'd5, 8'h10};
        tbl[4] = '{8'h0A, 6'd2, 8'h02};
        tbl[5] = '{8'hC0, 6'd7, 8'h40};

        rst_n = 1'b0; irq_req = 8'hFF; sreg_i = 1'b1; cpu_int_ack = 1'b0;
        read = 1'b0; write = 1'b0; addr = 8'h00; wdata = 8'h00;

        // Reset holds everything quiet even with all requests high
        tick(3);
        chk("rst_req", 32'(cpu_int_req), 32'd0);
        chk("rst_exec", 32'(irq_exec), 32'd0);
        chk("rst_vec", 32'(cpu_int_vec), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_req", 32'(cpu_int_req), 32'd1);
        chk("post_rst_vec", 32'(cpu_int_vec), 32'd1);
        do_ack(8'h01);
        go_idle();

        for (int i = 0; i < 6; i++) begin
            irq_req = tbl[i].req;
            sreg_i  = 1'b1;
            tick();
            chk($sformatf("tbl%0d_req", i), 32'(cpu_int_req), 32'd1);
            chk($sformatf("tbl%0d_vec", i), 32'(cpu_int_vec), 32'(tbl[i].vec));
            do_ack(tbl[i].exec);
            go_idle();
        end

        // Priority then lower source after HOLD
        irq_req = 8'h24;
        tick();
        chk("prio_vec3", 32'(cpu_int_vec), 32'd3);
        do_ack(8'h04);
        irq_req = 8'h20;
        tick();
        chk("prio_hold_req", 32'(cpu_int_req), 32'd0);
        wait_req("prio2", 6);
        chk("prio_vec6", 32'(cpu_int_vec), 32'd6);
        do_ack(8'h20);
        go_idle();

        // Held request re-arbitrates exactly after the 2-cycle HOLD
        irq_req = 8'h01;
        tick();
        do_ack(8'h01);
        tick(); chk("hold_c1", 32'(cpu_int_req), 32'd0);
        tick(); chk("hold_c2", 32'(cpu_int_req), 32'd0);
        tick(); chk("hold_rearb", 32'(cpu_int_req), 32'd1);
        do_ack(8'h01);
        go_idle();

        // Withdraw before ack
        irq_req = 8'h01;
        tick();
        chk("wd_req", 32'(cpu_int_req), 32'd1);
        irq_req = 8'h00;
        tick();
        chk("wd_drop", 32'(cpu_int_req), 32'd0);
        tick(5);
        go_idle();

        // Global enable
        sreg_i = 1'b0;
        irq_req = 8'h01;
        hits = 0;
        repeat (100) begin
            tick();
            if (cpu_int_req !== 1'b0) hits++;
        end
        chk("gie_off_hits", 32'(hits), 32'd0);
        sreg_i = 1'b1;
        tick();
        chk("gie_on_req", 32'(cpu_int_req), 32'd1);
        chk("gie_on_vec", 32'(cpu_int_vec), 32'd1);
        sreg_i = 1'b0;
        tick();
        chk("gie_withdraw", 32'(cpu_int_req), 32'd0);
        sreg_i = 1'b1;
        tick();
        chk("gie_again", 32'(cpu_int_req), 32'd1);
        do_ack(8'h01);
        go_idle();

        // Ack and withdraw together: ack wins and FSM enters HOLD
        irq_req = 8'h02;
        tick();
        chk("aw_vec", 32'(cpu_int_vec), 32'd2);
        cpu_int_ack = 1'b1;
        irq_req = 8'h00;
        exp_q.push_back(8'h02);
        tick();
        cpu_int_ack = 1'b0;
        chk("aw_req", 32'(cpu_int_req), 32'd0);
        irq_req = 8'h01;
        tick(); chk("aw_hold1", 32'(cpu_int_req), 32'd0);
        tick(); chk("aw_hold2", 32'(cpu_int_req), 32'd0);
        tick(); chk("aw_rearb", 32'(cpu_int_req), 32'd1);
        chk("aw_rearb_vec", 32'(cpu_int_vec), 32'd1);
        do_ack(8'h01);
        go_idle();

        // Ack while idle does nothing
        cpu_int_ack = 1'b1;
        tick();
        cpu_int_ack = 1'b0;
        chk("idle_ack_exec", 32'(irq_exec), 32'd0);
        chk("idle_ack_req", 32'(cpu_int_req), 32'd0);
        tick(3);

        // Reset coinciding with ack suppresses the pulse
        irq_req = 8'h04;
        tick();
        chk("rstmid_req", 32'(cpu_int_req), 32'd1);
        cpu_int_ack = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("rstmid_exec", 32'(irq_exec), 32'd0);
        chk("rstmid_req0", 32'(cpu_int_req), 32'd0);
        cpu_int_ack = 1'b0;
        irq_req = 8'h00;
        rst_n = 1'b1;
        tick(2);

`ifdef INT_CTRL_MASK_EN
        bus_write(8'h5A, 8'hFE);
        bus_read("mask_rd", 8'h5A, 8'hFE);
        irq_req = 8'h03;
        wait_req("mask", 3);
        chk("mask_vec", 32'(cpu_int_vec), 32'd2);
        bus_read("pend_rd", 8'h5B, 8'h02);
        bus_write(8'h5A, 8'hFC);
        chk("mask_clr_still", 32'(cpu_int_req), 32'd1);
        tick();
        chk("mask_clr_wd", 32'(cpu_int_req), 32'd0);
        bus_write(8'h5A, 8'hFF);
        wait_req("unmask", 3);
        chk("unmask_vec", 32'(cpu_int_vec), 32'd1);
        do_ack(8'h01);
        go_idle();
`endif

        tick(2);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
